// File: rtl/spirose_pkg.sv
// Constants and types shared by the slice RAM scheduler and the framebuffer.
package spirose_pkg;

  // Words per slice (40 x 48 pixels).
  localparam int unsigned IMAGE_SIZE    = 1920;
  // Default ring depth in slices.
  localparam int unsigned SLICES_IN_RAM = 18;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StStream
  } sched_state_t;

endpackage

// File: rtl/slice_ring_ptr.sv
// Write pointer over a ring of slices: pixel/slice counters, slice-complete pulse
// and absolute RAM address of the next pixel.
module slice_ring_ptr #(
  parameter int unsigned RAM_ADDR_WIDTH = 32,
  parameter int unsigned RAM_BASE       = 0,
  parameter int unsigned IMAGE_SIZE     = spirose_pkg::IMAGE_SIZE,
  parameter int unsigned SLICES_IN_RAM  = spirose_pkg::SLICES_IN_RAM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      advance,
  output logic [RAM_ADDR_WIDTH-1:0] addr,
  output logic                      slice_done
);

  localparam int unsigned PixW   = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int unsigned SliceW = (SLICES_IN_RAM > 1) ? $clog2(SLICES_IN_RAM) : 1;

  logic [PixW-1:0]   pix_q, pix_d;
  logic [SliceW-1:0] slice_q, slice_d;
  logic              pix_last, slice_last;

  assign pix_last   = (pix_q == PixW'(IMAGE_SIZE - 1));
  assign slice_last = (slice_q == SliceW'(SLICES_IN_RAM - 1));
  assign slice_done = advance && pix_last;

  assign addr = RAM_ADDR_WIDTH'(RAM_BASE)
              + RAM_ADDR_WIDTH'(slice_q) * RAM_ADDR_WIDTH'(IMAGE_SIZE)
              + RAM_ADDR_WIDTH'(pix_q);

  // Advance pixel, rolling over into the next slice of the ring.
  always_comb begin
    pix_d   = pix_q;
    slice_d = slice_q;
    if (advance) begin
      if (pix_last) begin
        pix_d   = '0;
        slice_d = slice_last ? '0 : slice_q + 1'b1;
      end else begin
        pix_d = pix_q + 1'b1;
      end
    end
  end

  // Pointer registers; clear returns to slice 0, pixel 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pix_q   <= '0;
      slice_q <= '0;
    end else begin
      pix_q   <= pix_d;
      slice_q <= slice_d;
    end
  end

endmodule

// File: rtl/ram_scheduler.sv
// Shares the single-port slice RAM between the RGB write stream and framebuffer
// reads, tracks buffered slices and signals when streaming may start.
module ram_scheduler #(
  parameter int unsigned RAM_ADDR_WIDTH   = 32,
  parameter int unsigned RAM_DATA_WIDTH   = 16,
  parameter int unsigned RAM_BASE         = 0,
  parameter int unsigned IMAGE_SIZE       = spirose_pkg::IMAGE_SIZE,
  parameter int unsigned SLICES_IN_RAM    = spirose_pkg::SLICES_IN_RAM,
  parameter int unsigned STREAM_THRESHOLD = 2,
  parameter int unsigned MAX_READ_BURST   = 15
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 wr_valid,
  input  logic [RAM_DATA_WIDTH-1:0]            wr_data,
  output logic                                 wr_ready,
  input  logic                                 rd_req,
  input  logic [RAM_ADDR_WIDTH-1:0]            rd_addr,
  output logic                                 rd_gnt,
  output logic                                 rd_valid,
  output logic [RAM_DATA_WIDTH-1:0]            rd_data,
  input  logic                                 slice_consumed,
  output logic                                 stream_ready,
  output logic [$clog2(SLICES_IN_RAM+1)-1:0]   fill_level,
  output logic                                 underrun,
  output logic [RAM_ADDR_WIDTH-1:0]            ram_addr,
  output logic [RAM_DATA_WIDTH-1:0]            ram_wdata,
  output logic                                 ram_we,
  input  logic [RAM_DATA_WIDTH-1:0]            ram_rdata
);

  import spirose_pkg::*;

  localparam int unsigned FillW  = $clog2(SLICES_IN_RAM + 1);
  localparam int unsigned BurstW = $clog2(MAX_READ_BURST + 1);
  localparam logic [FillW-1:0]  FillMax  = FillW'(SLICES_IN_RAM);
  localparam logic [FillW-1:0]  FillThr  = FillW'(STREAM_THRESHOLD);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_READ_BURST);

  sched_state_t              state_q, state_d;
  logic [FillW-1:0]          fill_q, fill_d;
  logic [BurstW-1:0]         burst_q, burst_d;
  logic                      underrun_q, underrun_d;
  logic                      stream_ready_q;
  logic                      rd_valid_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_hold_q;
  logic [RAM_ADDR_WIDTH-1:0] wr_addr;
  logic                      slice_done;
  logic                      wr_elig, rd_elig, wr_pending, burst_force, wr_acc, underrun_evt;

  // Grants are suppressed while rst is high so the reset cycle issues nothing.
  assign wr_elig     = !rst && (state_q != StIdle) && (fill_q < FillMax);
  assign rd_elig     = !rst && (state_q == StStream);
  assign wr_pending  = wr_valid && wr_elig;
  assign burst_force = wr_pending && (burst_q == BurstMax);
  assign rd_gnt      = rd_elig && rd_req && !burst_force;
  assign wr_ready    = wr_elig && !rd_gnt;
  assign wr_acc      = wr_ready && wr_valid;

  slice_ring_ptr #(
    .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH),
    .RAM_BASE       (RAM_BASE),
    .IMAGE_SIZE     (IMAGE_SIZE),
    .SLICES_IN_RAM  (SLICES_IN_RAM)
  ) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .clear      (!enable),
    .advance    (wr_acc),
    .addr       (wr_addr),
    .slice_done (slice_done)
  );

  // Fill counter and sticky underrun; coincident complete/consume cancel out.
  always_comb begin
    fill_d       = fill_q;
    underrun_d   = underrun_q;
    underrun_evt = 1'b0;
    if (slice_done && !slice_consumed) begin
      if (fill_q < FillMax) fill_d = fill_q + 1'b1;
    end else if (slice_consumed && !slice_done) begin
      if (fill_q == '0) underrun_evt = 1'b1;
      else              fill_d = fill_q - 1'b1;
    end
    if (underrun_evt) underrun_d = 1'b1;
    if (!enable) begin
      fill_d     = '0;
      underrun_d = 1'b0;
    end
  end

  // Next state; FILL looks at the updated count so streaming starts with it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable) state_d = StFill;
      StFill:   if (fill_d >= FillThr) state_d = StStream;
      StStream: if (underrun_evt) state_d = StFill;
      default:  state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;
  end

  // Read burst length while a write is kept waiting.
  always_comb begin
    burst_d = burst_q;
    if (!wr_valid || wr_acc)          burst_d = '0;
    else if (rd_gnt && wr_pending)    burst_d = burst_q + 1'b1;
    if (!enable) burst_d = '0;
  end

  // RAM port mux; address holds its last value when idle.
  always_comb begin
    ram_addr = addr_hold_q;
    if (rd_gnt)      ram_addr = rd_addr;
    else if (wr_acc) ram_addr = wr_addr;
  end

  assign ram_we       = wr_acc;
  assign ram_wdata    = wr_data;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_valid_q ? ram_rdata : '0;
  assign stream_ready = stream_ready_q;
  assign fill_level   = fill_q;
  assign underrun     = underrun_q;

  // State registers; rd_valid tracks a grant even in the cycle enable drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      fill_q         <= '0;
      burst_q        <= '0;
      underrun_q     <= 1'b0;
      stream_ready_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      addr_hold_q    <= RAM_ADDR_WIDTH'(RAM_BASE);
    end else begin
      state_q        <= state_d;
      fill_q         <= fill_d;
      burst_q        <= burst_d;
      underrun_q     <= underrun_d;
      stream_ready_q <= (state_d == StStream);
      rd_valid_q     <= rd_gnt;
      addr_hold_q    <= enable ? ram_addr : RAM_ADDR_WIDTH'(RAM_BASE);
    end
  end

endmodule
